accumulate_dump: RTL and testbench

- Integrate-and-dump stage directly downstream of the fixed-point multiply block.
- Consumes a stream of signed WIDTH-bit products qualified by in_nd.
- Sums each block of 2^N_LOG products and emits their mean as one signed WIDTH-bit sample, with metadata and error flag.
- Used for correlator and power-estimate averaging after multiply.

---
 rtl/accumulate_dump_pkg.sv | 22 ++
 rtl/accdump_scale.sv | 47 ++++
 rtl/accumulate_dump.sv | 99 +++++++++
 tb/tb_accumulate_dump.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/accumulate_dump_pkg.sv
// ---------------------------------------------------------------------------
// accumulate_dump_pkg : shared state encoding and accumulator width helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package accumulate_dump_pkg;

  typedef enum logic {
    ACCDUMP_EMPTY   = 1'b0,
    ACCDUMP_FILLING = 1'b1
  } accdump_state_e;

  // A block of 2^n_log full-scale samples needs exactly n_log guard bits.
  function automatic int accdump_acc_width(input int width, input int n_log);
    return width + n_log;
  endfunction

endpackage

`default_nettype wire

// File: rtl/accdump_scale.sv
// ---------------------------------------------------------------------------
// accdump_scale : block sum -> block mean (floor, or round-half-up + saturate
//                 when ACCDUMP_ROUND_EN is defined). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module accdump_scale
  import accumulate_dump_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_LOG = 4
) (
  input  logic signed [accdump_acc_width(WIDTH, N_LOG)-1:0] sum_i,
  output logic signed [WIDTH-1:0]                           data_o
);

  localparam int AW = accdump_acc_width(WIDTH, N_LOG);

`ifdef ACCDUMP_ROUND_EN
  localparam logic signed [AW:0]       HALF  = {{AW{1'b0}}, 1'b1} << (N_LOG - 1);
  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [AW:0] rounded;
  logic signed [AW:0] shifted;
  logic               sat_hi;
  logic               sat_lo;

  // One extra bit so adding the half-LSB cannot wrap the largest positive sum.
  assign rounded = {sum_i[AW-1], sum_i} + HALF;
  assign shifted = rounded >>> N_LOG;
  assign sat_hi  = ~shifted[AW] & (|shifted[AW-1:WIDTH-1]);
  assign sat_lo  =  shifted[AW] & ~(&shifted[AW-1:WIDTH-1]);
  assign data_o  = sat_hi ? MAX_V : (sat_lo ? MIN_V : shifted[WIDTH-1:0]);
`else
  logic signed [AW-1:0] shifted;
  logic                 unused_hi;

  assign shifted   = sum_i >>> N_LOG;
  assign data_o    = shifted[WIDTH-1:0];
  assign unused_hi = ^shifted[AW-1:WIDTH];
`endif

endmodule

`default_nettype wire

// File: rtl/accumulate_dump.sv
// ---------------------------------------------------------------------------
// accumulate_dump : integrate-and-dump of 2^N_LOG signed products to their
//                   mean. Optional rounding via ACCDUMP_ROUND_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module accumulate_dump
  import accumulate_dump_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MWIDTH = 1,
  parameter int N_LOG  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [WIDTH-1:0]  in_data,
  input  logic                     in_nd,
  input  logic        [MWIDTH-1:0] in_m,
  input  logic                     in_first,
  output logic signed [WIDTH-1:0]  out_data,
  output logic                     out_nd,
  output logic        [MWIDTH-1:0] out_m,
  output logic                     error
);

  localparam int             AW        = accdump_acc_width(WIDTH, N_LOG);
  localparam logic [N_LOG:0] BLOCK_LEN = {1'b1, {N_LOG{1'b0}}};
  localparam logic [N_LOG:0] ONE       = {{N_LOG{1'b0}}, 1'b1};

  accdump_state_e       state_q;
  logic [N_LOG:0]       count_q;
  logic [N_LOG:0]       count_d;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] sum_d;
  logic signed [AW-1:0] in_ext;
  logic [MWIDTH-1:0]    m_hold_q;
  logic [MWIDTH-1:0]    m_d;
  logic                 start;
  logic                 realign;
  logic                 dump;
  logic signed [WIDTH-1:0] scaled;

  assign in_ext = {{N_LOG{in_data[WIDTH-1]}}, in_data};

  // A forced start behaves exactly like a start from EMPTY, so one path serves both.
  always_comb begin
    realign = in_first && (state_q == ACCDUMP_FILLING);
    start   = (state_q == ACCDUMP_EMPTY) || in_first;
    sum_d   = start ? in_ext : (acc_q + in_ext);
    count_d = start ? ONE : (count_q + ONE);
    m_d     = start ? in_m : m_hold_q;
    dump    = in_nd && (count_d == BLOCK_LEN);
  end

  accdump_scale #(
    .WIDTH (WIDTH),
    .N_LOG (N_LOG)
  ) u_scale (
    .sum_i  (sum_d),
    .data_o (scaled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCDUMP_EMPTY;
      count_q  <= '0;
      acc_q    <= '0;
      m_hold_q <= '0;
      out_data <= '0;
      out_nd   <= 1'b0;
      out_m    <= '0;
      error    <= 1'b0;
    end else begin
      out_nd <= 1'b0;
      if (in_nd) begin
        if (realign) begin
          error <= 1'b1;
        end
        if (dump) begin
          out_data <= scaled;
          out_m    <= m_d;
          out_nd   <= 1'b1;
          state_q  <= ACCDUMP_EMPTY;
          count_q  <= '0;
          acc_q    <= '0;
        end else begin
          acc_q    <= sum_d;
          count_q  <= count_d;
          m_hold_q <= m_d;
          state_q  <= ACCDUMP_FILLING;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_accumulate_dump.sv
// ---------------------------------------------------------------------------
// tb_accumulate_dump : scoreboard bench for accumulate_dump (N_LOG=2). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_accumulate_dump;

  localparam int WIDTH  = 16;
  localparam int MWIDTH = 1;
  localparam int N_LOG  = 2;
`ifdef ACCDUMP_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic signed [WIDTH-1:0] in_data = '0;
  logic                    in_nd = 1'b0;
  logic [MWIDTH-1:0]       in_m = '0;
  logic                    in_first = 1'b0;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_nd;
  logic [MWIDTH-1:0]       out_m;
  logic                    error;

  always #5 clk = ~clk;

  accumulate_dump #(
    .WIDTH  (WIDTH),
    .MWIDTH (MWIDTH),
    .N_LOG  (N_LOG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_nd    (in_nd),
    .in_m     (in_m),
    .in_first (in_first),
    .out_data (out_data),
    .out_nd   (out_nd),
    .out_m    (out_m),
    .error    (error)
  );

  typedef struct {
    int data;
    int m;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every out_nd pulse must match the oldest queued expectation.
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && out_nd) begin
      if (sb.size() == 0) begin
        check("unexpected_out_nd", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_data", int'(out_data), e.data);
        check("out_m", int'(out_m), e.m);
        check("dump_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input int d, input int m = 0, input bit f = 1'b0,
                      input bit last = 1'b0, input int exp = 0, input int exp_m = 0);
    in_data  = d[WIDTH-1:0];
    in_m     = m[MWIDTH-1:0];
    in_first = f;
    in_nd    = 1'b1;
    if (last) sb.push_back('{exp, exp_m, cyc + 1});
    @(posedge clk);
    #1;
    in_nd    = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_nd", int'(out_nd), 0);
    check("reset_out_m", int'(out_m), 0);
    check("reset_error", int'(error), 0);
    rst_n = 1'b1;
    idle(1);

    // Basic mean
    send(4); send(8); send(12); send(16, 0, 0, 1, 10, 0);
    drain();
    check("basic_error", int'(error), 0);

    // Negative floor / round
    send(-1, 1); send(-1); send(-1); send(-2, 0, 0, 1, ROUND ? -1 : -2, 1);
    // Small positive remainder
    send(1); send(1); send(1); send(0, 0, 0, 1, ROUND ? 1 : 0, 0);
    // Extremes
    send(32767, 1); send(32767); send(32767); send(32767, 0, 0, 1, 32767, 1);
    send(-32768); send(-32768); send(-32768); send(-32768, 0, 0, 1, -32768, 0);
    drain();

    // Gaps 1,0,0,1,0,1,1 with metadata of the first sample kept
    send(5, 1); idle(2); send(7, 0); idle(1); send(9, 0); send(11, 0, 0, 1, 8, 1);
    drain();
    idle(5);
    check("hold_out_data", int'(out_data), 8);
    check("hold_out_m", int'(out_m), 1);
    check("hold_out_nd", int'(out_nd), 0);

    // Realign: partial block of two dropped
    send(50, 0); send(60, 0); send(100, 1, 1); send(100); send(100);
    send(100, 0, 0, 1, 100, 1);
    drain();
    check("realign_error", int'(error), 1);

    // Reset mid-block
    send(100); send(100);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_out_m", int'(out_m), 0);
    check("midrst_out_nd", int'(out_nd), 0);
    check("midrst_error", int'(error), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    send(2); send(4); idle(2);
    send(6); send(8, 0, 0, 1, 5, 0);
    drain();
    check("post_rst_error", int'(error), 0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
